// File: rtl/axi_to_data_serializer.sv
// AXI4-Stream beat to single-element stream serializer, lowest element first.
// Define SERIALIZER_SKIP_EMPTY_EN to emit only elements whose keep is set.
module axi_to_data_serializer #(
  parameter type         data_t       = logic [15:0],
  parameter int unsigned AXI_WIDTH    = 512,
  parameter int unsigned DATA_WIDTH   = $bits(data_t),
  parameter int unsigned NUM_ELEMENTS = AXI_WIDTH / DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AXI_WIDTH-1:0]   in_tdata,
  input  logic [AXI_WIDTH/8-1:0] in_tkeep,
  input  logic                   in_tlast,
  input  logic                   in_tvalid,
  output logic                   in_tready,
  output data_t                  out_data,
  output logic                   out_keep,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int unsigned IdxW         = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
  localparam int unsigned BytesPerElem = DATA_WIDTH / 8;

  if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if (NUM_ELEMENTS == 0 || NUM_ELEMENTS * DATA_WIDTH != AXI_WIDTH) begin : g_bad_num_elements
    $error("NUM_ELEMENTS * DATA_WIDTH must equal AXI_WIDTH");
  end

  typedef enum logic {StEmpty, StSerial} state_e;

  state_e                         state_q, state_d;
  logic   [IdxW-1:0]              idx_q, idx_d;
  data_t  [NUM_ELEMENTS-1:0]      beat_q;
  logic   [NUM_ELEMENTS-1:0]      ek_q;
  logic                           last_q;

  logic   [NUM_ELEMENTS-1:0]      ek_in;
  logic   [IdxW-1:0]              nxt_idx, first_idx;
  logic                           fin, load_held, held, in_hs, out_hs;
  logic                           unused_tkeep;

  // Only the lowest byte's keep bit qualifies an element.
  always_comb begin
    ek_in = '0;
    for (int i = 0; i < int'(NUM_ELEMENTS); i++) begin
      ek_in[i] = in_tkeep[i*BytesPerElem];
    end
  end
  assign unused_tkeep = ^in_tkeep;

`ifdef SERIALIZER_SKIP_EMPTY_EN
  logic nxt_found, in_any;

  // Descending scans leave the lowest qualifying index in the result.
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = '0;
    in_any    = 1'b0;
    first_idx = '0;
    for (int i = int'(NUM_ELEMENTS) - 1; i >= 0; i--) begin
      if (ek_q[i] && (i > int'(idx_q))) begin
        nxt_found = 1'b1;
        nxt_idx   = IdxW'(i);
      end
      if (ek_in[i]) begin
        in_any    = 1'b1;
        first_idx = IdxW'(i);
      end
    end
  end

  assign fin       = !nxt_found;
  // An all-empty beat is only worth holding if it closes a packet.
  assign load_held = in_any || in_tlast;
`else
  assign nxt_idx   = idx_q + 1'b1;
  assign first_idx = '0;
  assign fin       = (idx_q == IdxW'(NUM_ELEMENTS - 1));
  assign load_held = 1'b1;
`endif

  assign held      = (state_q == StSerial);
  assign out_valid = held;
  assign out_data  = held ? beat_q[idx_q] : '0;
  assign out_keep  = held & ek_q[idx_q];
  assign out_last  = held & last_q & fin;

  assign out_hs    = out_valid && out_ready;
  assign in_tready = !rst && (!held || (out_ready && fin));
  assign in_hs     = in_tvalid && in_tready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (out_hs) begin
      if (!fin) begin
        idx_d = nxt_idx;
      end else begin
        state_d = StEmpty;
        idx_d   = '0;
      end
    end
    // A load overrides the final-element drain in the same cycle.
    if (in_hs) begin
      state_d = load_held ? StSerial : StEmpty;
      idx_d   = first_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      idx_q   <= '0;
      beat_q  <= '0;
      ek_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (in_hs) begin
        beat_q <= in_tdata;
        ek_q   <= ek_in;
        last_q <= in_tlast;
      end
    end
  end

endmodule

// File: doc/axi_to_data_serializer.md
# axi_to_data_serializer

Parametrised AXI4-Stream to `data_i` serializer: accepts one `AXI_WIDTH` beat and emits its `NUM_ELEMENTS` elements one per cycle, lowest element first. It supports any element count, including non-power-of-two counts, with correct index wrap. It registers the held beat, sustains one element per cycle across beat boundaries, and can optionally compact away elements whose keep is low. It sits between host/memory AXI streams and single-element `data_i` operator pipelines, and is the general replacement for fixed-ratio AXI-to-data adapters.

## Interface
Parameters:
- `data_t`, no default, element type.
- `AXI_WIDTH`, 512, input stream width in bits.
- `DATA_WIDTH`, `$bits(data_t)`, element width in bits; must be a multiple of 8.
- `NUM_ELEMENTS`, `AXI_WIDTH / DATA_WIDTH`, elements per beat; must be ≥1 and satisfy `NUM_ELEMENTS * DATA_WIDTH == AXI_WIDTH`. Violations are elaboration errors.

Ports:
- `clk`, input, 1: single clock; all logic is on its rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `in`, `AXI4S.s`, `AXI_WIDTH`: input stream (`tdata`, `tkeep`, `tlast`, `tvalid`, `tready`).
- `out`, `data_i.m`, `data_t`: element stream (`data`, `keep`, `last`, `valid`, `ready`).

## Operation
- State:
  - `held` (1b): a beat is buffered.
  - Beat register: data, per-element keep vector `ek[NUM_ELEMENTS]`, tlast.
  - `idx`: `$clog2(NUM_ELEMENTS)` bits, minimum 1.
- Element keep: `ek[i] = in.tkeep[i*DATA_WIDTH/8]`, i.e. the keep bit of the element's lowest byte.
- Two states:
  - EMPTY (`held=0`).
  - SERIAL (`held=1`).
- Final element: `fin` is true when `idx` is the last element to emit for the held beat.
- Input acceptance: `in.tready = !held || (out.valid && out.ready && fin)`. A beat may load in the same cycle the previous beat's final element is consumed.
- On an input handshake:
  - Load the beat register and set `held=1`.
  - Set `idx` to the first element to emit: 0, or the lowest kept element when compaction is enabled.
- Output signals are driven from `held`, the beat register and `idx`:
  - `out.valid = held`.
  - `out.data = beat[idx]`.
  - `out.keep = ek[idx]`.
  - `out.last = tlast && fin`.
  - No path from `in.*` reaches `out.*` combinationally.
- On an output handshake:
  - If `!fin`, advance `idx` to the next element to emit.
  - If `fin` and no new beat loads this cycle, clear `held` and reset `idx` to 0.
- Index wrap: `idx` never exceeds `NUM_ELEMENTS-1`. After element `NUM_ELEMENTS-1`, the next value is 0 or a new load, never `idx+1` modulo 2^w.
- Back-pressure:
  - With `out.ready` low, `out.*` stay stable.
  - `in.tready` is low whenever `held=1` and `fin` is not being consumed.
- `NUM_ELEMENTS==1`: degenerates to a one-deep register slice. Every element is `fin`; `out.keep = ek[0]`.
- Reset mid-operation: the held beat is discarded, with no partial flush. Upstream must restart the packet.

## Timing
- Reset values:
  - `out.valid=0`, `out.data=0`, `out.keep=0`, `out.last=0`.
  - `held=0`, `idx=0`.
  - `in.tready=0` while `rst=1`, and 1 in the first cycle after deassertion.
- Latency: element 0 of a beat is valid 1 cycle after its input handshake.
- Throughput: with `out.ready` held high, one element per cycle, with no bubble between consecutive beats. A full beat takes `NUM_ELEMENTS` cycles.
- Simultaneous final-element consume and input handshake: `held` stays 1, the beat register is replaced, and `idx` is set to the new beat's first element.

## Configuration
- Macro `SERIALIZER_SKIP_EMPTY_EN`.
- Undefined:
  - Every beat emits exactly `NUM_ELEMENTS` elements.
  - Elements with `ek=0` are emitted with `out.keep=0`.
  - `fin = (idx == NUM_ELEMENTS-1)`.
- Defined:
  - Only kept elements are emitted, in ascending order, by priority search over `ek` above `idx`.
  - `fin` is true when no kept element exists above `idx`.
  - Beat with `ek` all zero and `tlast=0`: accepted and dropped; `held` stays 0 and nothing is emitted.
  - Beat with `ek` all zero and `tlast=1`: exactly one element is emitted (element 0, `keep=0`, `last=1`), so packet boundaries are preserved.

## Test plan
All scenarios use `AXI_WIDTH=64` and `DATA_WIDTH=16` unless stated.
- Reset: hold `rst` for 3 cycles with `in.tvalid=1` → `in.tready=0` and `out.valid=0`; after release, `in.tready=1` and the beat is accepted.
- Full beat: `tdata=0x4444_3333_2222_1111`, `tkeep=0xFF`, `tlast=1`, `out.ready=1` → elements 0x1111, 0x2222, 0x3333, 0x4444 on 4 consecutive cycles starting 1 cycle after the handshake; `last` only on 0x4444.
- Back-to-back: two beats with `tvalid` held high → 8 elements with no gap; the second beat is accepted in the same cycle 0x4444 is consumed.
- Non-power-of-two: `AXI_WIDTH=48`, 3 elements, 3 beats → 9 elements in order; `idx` returns to 0 after element 2 and never reaches 3.
- Back-pressure: toggle `out.ready` 1-0-0-1 → `out.*` are stable while `out.ready` is low, with no duplicated or lost elements.
- Compaction (macro defined):
  - `tkeep=0x0C`, `tlast=1` → a single element 0x2222 with `keep=1`, `last=1`.
  - `tkeep=0x00`, `tlast=0` → nothing emitted.
  - `tkeep=0x00`, `tlast=1` → one element with `keep=0`, `last=1`.
  - Undefined macro with `tkeep=0x0C` → 4 elements with `keep` pattern 0, 1, 0, 0.
